// File: rtl/multi_colour_bbox.sv
// Multi-class colour bounding-box detector with video overlay and CPU message FIFO.
// Define MCB_PIXCOUNT_MSG_EN to append a per-class pixel-count word (BOXC) to each burst.
module multi_colour_bbox #(
  parameter int          IMAGE_W      = 640,
  parameter int          IMAGE_H      = 480,
  parameter int          NUM_COL      = 3,
  parameter int          MSG_INTERVAL = 6,
  parameter int          FIFO_DEPTH   = 64,
  parameter int          MIN_PIX      = 16,
  parameter logic [23:0] BB_COL_DEF   = 24'h00ff00
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s_chipselect,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [3:0]  s_address,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  input  logic [23:0] sink_data,
  input  logic        sink_valid,
  input  logic        sink_sop,
  input  logic        sink_eop,
  output logic        sink_ready,
  output logic [23:0] source_data,
  output logic        source_valid,
  output logic        source_sop,
  output logic        source_eop,
  input  logic        source_ready,
  input  logic        mode
);

  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef MCB_PIXCOUNT_MSG_EN
  localparam int WPC = 3;
  typedef enum logic [2:0] {IDLE, HDR, BOXA, BOXB, BOXC} st_t;
`else
  localparam int WPC = 2;
  typedef enum logic [2:0] {IDLE, HDR, BOXA, BOXB} st_t;
`endif
  localparam int BURST = 1 + WPC * NUM_COL;

  logic [23:0] r_min [NUM_COL];
  logic [23:0] r_max [NUM_COL];
  logic [23:0] r_bb_col;
  logic [7:0]  r_status;

  logic        r_video;
  logic [10:0] r_x, r_y;

  logic [10:0] r_sxmin [NUM_COL];
  logic [10:0] r_sxmax [NUM_COL];
  logic [10:0] r_symin [NUM_COL];
  logic [10:0] r_symax [NUM_COL];
  logic [19:0] r_scnt  [NUM_COL];
  logic [10:0] w_nxmin [NUM_COL];
  logic [10:0] w_nxmax [NUM_COL];
  logic [10:0] w_nymin [NUM_COL];
  logic [10:0] w_nymax [NUM_COL];
  logic [19:0] w_ncnt  [NUM_COL];
  logic [10:0] r_lxmin [NUM_COL];
  logic [10:0] r_lxmax [NUM_COL];
  logic [10:0] r_lymin [NUM_COL];
  logic [10:0] r_lymax [NUM_COL];
  logic [19:0] r_lcnt  [NUM_COL];
  logic [NUM_COL-1:0] r_lvalid;

  logic [31:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_used, w_free;
  st_t         r_state;
  logic [1:0]  r_k;
  logic [7:0]  r_fid;
  logic [15:0] r_fcnt;
  logic        r_rd1_d;

  logic        w_acc, w_vid_sop, w_vid_pix, w_vid_eop;
  logic [NUM_COL-1:0] w_match;
  logic        w_edge, w_hit;
  logic [23:0] w_hcol, w_pix;
  logic [7:0]  w_grey;
  logic        w_rd1, w_pop, w_push, w_flush, w_start, w_last_k;
  logic [31:0] w_word, w_rdata;
  logic        w_unused;

  assign w_unused = ^s_writedata[31:24];

  function automatic logic in_win(input logic [23:0] d,
                                  input logic [23:0] mn,
                                  input logic [23:0] mx);
    return (d[23:16] >= mn[23:16]) && (d[23:16] <= mx[23:16]) &&
           (d[15:8]  >= mn[15:8])  && (d[15:8]  <= mx[15:8])  &&
           (d[7:0]   >= mn[7:0])   && (d[7:0]   <= mx[7:0]);
  endfunction

  assign sink_ready = source_ready | ~source_valid;
  assign w_acc      = sink_valid & sink_ready;
  assign w_vid_sop  = w_acc & sink_sop & (sink_data[3:0] == 4'h0);
  assign w_vid_pix  = w_acc & ~sink_sop & r_video;
  assign w_vid_eop  = w_vid_pix & sink_eop;

  always_comb begin
    for (int k = 0; k < NUM_COL; k++) begin
      w_match[k] = in_win(sink_data, r_min[k], r_max[k]);
      w_nxmin[k] = r_sxmin[k];
      w_nxmax[k] = r_sxmax[k];
      w_nymin[k] = r_symin[k];
      w_nymax[k] = r_symax[k];
      w_ncnt[k]  = r_scnt[k];
      if (w_match[k]) begin
        if (r_x < r_sxmin[k]) w_nxmin[k] = r_x;
        if (r_x > r_sxmax[k]) w_nxmax[k] = r_x;
        if (r_y < r_symin[k]) w_nymin[k] = r_y;
        if (r_y > r_symax[k]) w_nymax[k] = r_y;
        if (r_scnt[k] != 20'hfffff) w_ncnt[k] = r_scnt[k] + 20'd1;
      end
    end
  end

  always_comb begin
    w_edge = 1'b0;
    for (int k = 0; k < NUM_COL; k++) begin
      if (r_lvalid[k] &&
          ((((r_x == r_lxmin[k]) || (r_x == r_lxmax[k])) &&
            (r_y >= r_lymin[k]) && (r_y <= r_lymax[k])) ||
           (((r_y == r_lymin[k]) || (r_y == r_lymax[k])) &&
            (r_x >= r_lxmin[k]) && (r_x <= r_lxmax[k]))))
        w_edge = 1'b1;
    end
    w_hit  = 1'b0;
    w_hcol = '0;
    // Descending scan so the lowest-index matching class wins.
    for (int k = NUM_COL - 1; k >= 0; k--) begin
      if (w_match[k]) begin
        w_hit  = 1'b1;
        w_hcol = r_max[k];
      end
    end
    w_grey = {1'b0, sink_data[15:9]} + {2'b0, sink_data[23:18]} +
             {2'b0, sink_data[7:2]};
    w_pix  = sink_data;
    if (mode && r_video && !sink_sop) begin
      if (w_edge)     w_pix = r_bb_col;
      else if (w_hit) w_pix = w_hcol;
      else            w_pix = {3{w_grey}};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      source_valid <= 1'b0;
      source_sop   <= 1'b0;
      source_eop   <= 1'b0;
      source_data  <= '0;
    end else if (sink_ready) begin
      source_valid <= sink_valid;
      if (sink_valid) begin
        source_data <= w_pix;
        source_sop  <= sink_sop;
        source_eop  <= sink_eop;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_video <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
    end else if (w_acc) begin
      if (sink_sop) begin
        r_video <= (sink_data[3:0] == 4'h0);
        r_x     <= '0;
        r_y     <= '0;
      end else if (r_x == 11'(IMAGE_W - 1)) begin
        r_x <= '0;
        r_y <= r_y + 11'd1;
      end else begin
        r_x <= r_x + 11'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || w_vid_sop) begin
      for (int k = 0; k < NUM_COL; k++) begin
        r_sxmin[k] <= 11'(IMAGE_W - 1);
        r_symin[k] <= 11'(IMAGE_H - 1);
        r_sxmax[k] <= '0;
        r_symax[k] <= '0;
        r_scnt[k]  <= '0;
      end
    end else if (w_vid_pix) begin
      for (int k = 0; k < NUM_COL; k++) begin
        r_sxmin[k] <= w_nxmin[k];
        r_sxmax[k] <= w_nxmax[k];
        r_symin[k] <= w_nymin[k];
        r_symax[k] <= w_nymax[k];
        r_scnt[k]  <= w_ncnt[k];
      end
    end
  end

  // The eop beat is itself a pixel, so latch the post-update stats.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_lvalid <= '0;
      for (int k = 0; k < NUM_COL; k++) begin
        r_lxmin[k] <= '0;
        r_lxmax[k] <= '0;
        r_lymin[k] <= '0;
        r_lymax[k] <= '0;
        r_lcnt[k]  <= '0;
      end
    end else if (w_vid_eop) begin
      for (int k = 0; k < NUM_COL; k++) begin
        r_lxmin[k]  <= w_nxmin[k];
        r_lxmax[k]  <= w_nxmax[k];
        r_lymin[k]  <= w_nymin[k];
        r_lymax[k]  <= w_nymax[k];
        r_lcnt[k]   <= w_ncnt[k];
        r_lvalid[k] <= (w_ncnt[k] >= 20'(MIN_PIX));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_status <= '0;
      r_bb_col <= BB_COL_DEF;
      for (int k = 0; k < NUM_COL; k++) begin
        r_min[k] <= 24'hffffff;
        r_max[k] <= 24'h000000;
      end
    end else if (s_chipselect && s_write) begin
      if (s_address == 4'd0) r_status <= s_writedata[7:0] & 8'hef;
      if (s_address == 4'd3) r_bb_col <= s_writedata[23:0];
      for (int k = 0; k < NUM_COL; k++) begin
        if (s_address == 4'(4 + 2 * k)) r_min[k] <= s_writedata[23:0];
        if (s_address == 4'(5 + 2 * k)) r_max[k] <= s_writedata[23:0];
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    case (s_address)
      4'd0: w_rdata = {16'b0, 8'(r_used), r_status};
      4'd1: if (r_used != '0) w_rdata = r_mem[r_rptr];
      4'd2: w_rdata = 32'h1234EEE3;
      4'd3: w_rdata = {8'b0, r_bb_col};
      default: ;
    endcase
    for (int k = 0; k < NUM_COL; k++) begin
      if (s_address == 4'(4 + 2 * k)) w_rdata = {8'b0, r_min[k]};
      if (s_address == 4'(5 + 2 * k)) w_rdata = {8'b0, r_max[k]};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n)                    s_readdata <= '0;
    else if (s_chipselect && s_read) s_readdata <= w_rdata;
  end

  assign w_rd1    = s_chipselect & s_read & (s_address == 4'd1);
  assign w_flush  = s_chipselect & s_write & (s_address == 4'd0) &
                    s_writedata[4];
  assign w_pop    = w_rd1 & ~r_rd1_d & (r_used != '0) & ~w_flush;
  assign w_push   = (r_state != IDLE) & ~w_flush;
  assign w_free   = (AW + 1)'(FIFO_DEPTH) - r_used;
  assign w_start  = w_vid_eop & (r_fcnt == '0) & (r_state == IDLE) &
                    (w_free >= (AW + 1)'(BURST)) & ~w_flush;
  assign w_last_k = (r_k == 2'(NUM_COL - 1));

  always_comb begin
    w_word = '0;
    case (r_state)
      HDR:  w_word = {16'h4D42, r_fid, 4'h0, 4'(NUM_COL)};
      BOXA: w_word = {r_lvalid[r_k], 1'b0, r_k, 1'b0, r_lxmin[r_k],
                      5'b0, r_lymin[r_k]};
      BOXB: w_word = {5'b0, r_lxmax[r_k], 5'b0, r_lymax[r_k]};
`ifdef MCB_PIXCOUNT_MSG_EN
      BOXC: w_word = {1'b0, r_k, 9'b0, r_lcnt[r_k]};
`endif
      default: w_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_word;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_fid   <= '0;
      r_fcnt  <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_used  <= '0;
      r_rd1_d <= 1'b0;
    end else begin
      r_rd1_d <= w_rd1;
      // A skipped burst leaves the counter at zero so the next eop retries.
      if (w_start)                         r_fcnt <= 16'(MSG_INTERVAL - 1);
      else if (w_vid_eop && r_fcnt != '0)  r_fcnt <= r_fcnt - 16'd1;
      if (w_flush) begin
        r_state <= IDLE;
        r_k     <= '0;
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_used  <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop)  r_rptr <= r_rptr + 1'b1;
        r_used <= r_used + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        case (r_state)
          IDLE: if (w_start) r_state <= HDR;
          HDR: begin
            r_state <= BOXA;
            r_k     <= '0;
            r_fid   <= r_fid + 8'd1;
          end
          BOXA: r_state <= BOXB;
`ifdef MCB_PIXCOUNT_MSG_EN
          BOXB: r_state <= BOXC;
          BOXC: begin
`else
          BOXB: begin
`endif
            r_state <= w_last_k ? IDLE : BOXA;
            r_k     <= r_k + 2'd1;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multi_colour_bbox.sv
// Directed bench for multi_colour_bbox on a reduced 16x8 image and 16-word FIFO.
module tb_multi_colour_bbox;
  localparam int W  = 16;
  localparam int H  = 8;
  localparam int NP = W * H;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        s_chipselect, s_read, s_write;
  logic [3:0]  s_address;
  logic [31:0] s_writedata, s_readdata;
  logic [23:0] sink_data, source_data;
  logic        sink_valid, sink_sop, sink_eop, sink_ready;
  logic        source_valid, source_sop, source_eop, source_ready;
  logic        mode;

  int checks = 0;
  int errors = 0;
  logic [25:0] outq[$];
  logic [31:0] rd;

  always #5 clk = ~clk;

  multi_colour_bbox #(
    .IMAGE_W(W), .IMAGE_H(H), .NUM_COL(3), .MSG_INTERVAL(2),
    .FIFO_DEPTH(16), .MIN_PIX(16), .BB_COL_DEF(24'h00ff00)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .s_chipselect(s_chipselect), .s_read(s_read), .s_write(s_write),
    .s_address(s_address), .s_writedata(s_writedata),
    .s_readdata(s_readdata),
    .sink_data(sink_data), .sink_valid(sink_valid),
    .sink_sop(sink_sop), .sink_eop(sink_eop), .sink_ready(sink_ready),
    .source_data(source_data), .source_valid(source_valid),
    .source_sop(source_sop), .source_eop(source_eop),
    .source_ready(source_ready), .mode(mode)
  );

  always @(negedge clk)
    if (source_valid && source_ready)
      outq.push_back({source_sop, source_eop, source_data});

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] pix(input int x, input int y);
    if (x >= 3 && x <= 9 && y >= 2 && y <= 5) return 24'hff1010;
    if (y == 7 && x < 10) return 24'h1010ff;
    return 24'h808080;
  endfunction

  function automatic logic [23:0] ovl(input int x, input int y);
    if (((x == 3 || x == 9) && y >= 2 && y <= 5) ||
        ((y == 2 || y == 5) && x >= 3 && x <= 9)) return 24'h00ff00;
    if (x >= 3 && x <= 9 && y >= 2 && y <= 5) return 24'hff3f3f;
    if (y == 7 && x < 10) return 24'h3f3fff;
    return 24'h808080;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [23:0] d, input logic sop,
                      input logic eop);
    logic got;
    int   n;
    n = 0;
    sink_data  = d;
    sink_sop   = sop;
    sink_eop   = eop;
    sink_valid = 1'b1;
    do begin
      @(negedge clk);
      got = sink_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!got && n < 50);
    if (!got) chk("beat_timeout", 32'(got), 32'd1);
    sink_valid = 1'b0;
  endtask

  task automatic stall_beat(input logic [23:0] d, input logic eop);
    source_ready = 1'b0;
    fork
      beat(d, 1'b0, eop);
      begin
        repeat (5) begin
          @(negedge clk);
          chk("stall_valid", 32'(source_valid), 32'd1);
          chk("stall_data", 32'(source_data), 32'h00ff3f3f);
          chk("stall_sink_ready", 32'(sink_ready), 32'd0);
        end
        @(posedge clk);
        #1 source_ready = 1'b1;
      end
    join
  endtask

  task automatic send_frame(input bit stall_en);
    beat(24'h123450, 1'b1, 1'b0);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        if (stall_en && y == 3 && x == 6)
          stall_beat(pix(x, y), 1'b0);
        else
          beat(pix(x, y), 1'b0, (y == H - 1) && (x == W - 1));
      end
  endtask

  task automatic mm_write(input logic [3:0] a, input logic [31:0] d);
    s_chipselect = 1'b1;
    s_write      = 1'b1;
    s_address    = a;
    s_writedata  = d;
    tick(1);
    s_chipselect = 1'b0;
    s_write      = 1'b0;
  endtask

  task automatic mm_read(input logic [3:0] a, output logic [31:0] d);
    s_chipselect = 1'b1;
    s_read       = 1'b1;
    s_address    = a;
    tick(1);
    s_chipselect = 1'b0;
    s_read       = 1'b0;
    d = s_readdata;
    tick(1);
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a,
                        input logic [31:0] exp);
    logic [31:0] v;
    mm_read(a, v);
    chk(tag, v, exp);
  endtask

  initial begin
    logic [31:0] msg1 [7];
    msg1 = '{32'h4D420003, 32'h80030002, 32'h00090005, 32'h10000007,
             32'h00090007, 32'h200F0007, 32'h00000000};
    reset_n = 1'b0;
    s_chipselect = 1'b0; s_read = 1'b0; s_write = 1'b0;
    s_address = '0; s_writedata = '0;
    sink_data = '0; sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
    source_ready = 1'b1; mode = 1'b0;
    tick(3);
    reset_n = 1'b1;
    chk("rst_src_valid", 32'(source_valid), 32'd0);
    chk("rst_src_data", 32'(source_data), 32'd0);
    chk("rst_readdata", s_readdata, 32'd0);
    chk("rst_sink_ready", 32'(sink_ready), 32'd1);
    rd_chk("rst_status", 4'd0, 32'h0);
    rd_chk("id", 4'd2, 32'h1234EEE3);
    rd_chk("rst_bbcol", 4'd3, 32'h0000ff00);
    rd_chk("rst_min0", 4'd4, 32'h00ffffff);
    rd_chk("rst_max2", 4'd9, 32'h0);
    mm_write(4'd0, 32'hA5);
    rd_chk("status_wr", 4'd0, 32'h000000A5);
    mm_write(4'd0, 32'h0);
    mm_write(4'd12, 32'h00abcdef);
    rd_chk("unmapped", 4'd12, 32'h0);
    rd_chk("empty_pop", 4'd1, 32'h0);

    mm_write(4'd4, 32'hff0000);
    mm_write(4'd5, 32'hff3f3f);
    mm_write(4'd6, 32'h0000ff);
    mm_write(4'd7, 32'h3f3fff);
    rd_chk("max1_rb", 4'd7, 32'h003f3fff);

    outq.delete();
    send_frame(1'b0);
    tick(2);
    chk("f1_beats", 32'(outq.size()), 32'(NP + 1));
    chk("f1_sop", 32'(outq[0]), {6'b0, 2'b10, 24'h123450});
    for (int i = 0; i < NP; i++)
      chk("f1_pass", 32'(outq[i + 1]),
          {6'b0, 1'b0, i == NP - 1, pix(i % W, i / W)});
    tick(10);
    rd_chk("f1_used", 4'd0, 32'h00000700);
    for (int i = 0; i < 7; i++) rd_chk("f1_msg", 4'd1, msg1[i]);
    rd_chk("f1_drained", 4'd0, 32'h0);
    rd_chk("f1_empty_pop", 4'd1, 32'h0);

    mode = 1'b1;
    outq.delete();
    send_frame(1'b1);
    tick(2);
    chk("f2_beats", 32'(outq.size()), 32'(NP + 1));
    chk("f2_sop", 32'(outq[0]), {6'b0, 2'b10, 24'h123450});
    for (int i = 0; i < NP; i++)
      chk("f2_ovl", 32'(outq[i + 1]),
          {6'b0, 1'b0, i == NP - 1, ovl(i % W, i / W)});
    tick(10);
    rd_chk("f2_no_burst", 4'd0, 32'h0);

    outq.delete();
    beat(24'h123453, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) beat(24'hff1010, 1'b0, i == 3);
    tick(2);
    chk("nv_beats", 32'(outq.size()), 32'd5);
    chk("nv_sop", 32'(outq[0]), {6'b0, 2'b10, 24'h123453});
    chk("nv_pix", 32'(outq[2]), {8'b0, 24'hff1010});
    chk("nv_eop", 32'(outq[4]), {6'b0, 2'b01, 24'hff1010});
    tick(10);
    rd_chk("nv_no_burst", 4'd0, 32'h0);
    mode = 1'b0;

    for (int f = 3; f <= 7; f++) send_frame(1'b0);
    tick(10);
    rd_chk("fill_used", 4'd0, 32'h00000E00);
    rd_chk("fill_hdr1", 4'd1, 32'h4D420103);
    for (int i = 0; i < 6; i++) mm_read(4'd1, rd);
    rd_chk("fill_hdr2", 4'd1, 32'h4D420203);
    rd_chk("after_pops", 4'd0, 32'h00000600);
    send_frame(1'b0);
    tick(10);
    rd_chk("retry_used", 4'd0, 32'h00000D00);

    mm_write(4'd0, 32'h10);
    rd_chk("flush_used", 4'd0, 32'h0);
    send_frame(1'b0);
    send_frame(1'b0);
    tick(1);
    mm_write(4'd0, 32'h10);
    rd_chk("mid_flush_used", 4'd0, 32'h0);
    tick(10);
    rd_chk("mid_flush_idle", 4'd0, 32'h0);
    rd_chk("mid_flush_empty", 4'd1, 32'h0);
    send_frame(1'b0);
    send_frame(1'b0);
    tick(10);
    rd_chk("post_flush_used", 4'd0, 32'h00000700);
    rd_chk("post_flush_hdr", 4'd1, 32'h4D420503);
    rd_chk("post_flush_boxa", 4'd1, 32'h80030002);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
